// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: pixel divider, x/y counters, line/frame strobes, syncs and ADV7123 controls.
// Syncs and blank are delayed OUT_DELAY pixels so they line up with colour returned by the renderers.
module vga_timing_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_VIS     = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VIS     = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int OUT_DELAY = 1
) (
  input  logic       clk,
  input  logic       reset,
  output logic       pix_tick,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic       hsync,
  output logic       vsync,
  output logic       vga_blank_n,
  output logic       vga_sync_n,
  output logic       vga_clk
);

  localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] DIV_LAST = 4'(CLK_DIV - 1);
  localparam logic [3:0] DIV_HALF = 4'(CLK_DIV / 2);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_W  = 10'(H_VIS);
  localparam logic [9:0] V_VIS_W  = 10'(V_VIS);
  localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

  // Delay-stage word layout: {hsync, vsync, blank_n}; idle is syncs high, blanked.
  localparam logic [2:0] STAGE_RST = 3'b110;

  logic [3:0] div_q, div_d;
  logic       tick_q;
  logic       vclk_q;
  logic       line_q;
  logic       frame_q;
  logic [9:0] x_q, x_d;
  logic [9:0] y_q, y_d;
  logic       x_wrap;
  logic       y_wrap;
  logic [2:0] raw_d;
  logic [2:0] stage_q [0:OUT_DELAY];

  always_comb begin
    div_d  = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
    x_wrap = (x_q == H_LAST);
    y_wrap = (y_q == V_LAST);
    x_d    = x_q;
    y_d    = y_q;
    if (tick_q) begin
      x_d = x_wrap ? 10'd0 : x_q + 10'd1;
      if (x_wrap) begin
        y_d = y_wrap ? 10'd0 : y_q + 10'd1;
      end
    end
    // Raw values are computed from the next coordinates so stage 0 tracks x/y edge for edge.
    raw_d = {~((x_d >= HS_START) && (x_d < HS_END)),
             ~((y_d >= VS_START) && (y_d < VS_END)),
             (x_d < H_VIS_W) && (y_d < V_VIS_W)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q      <= 4'd0;
      tick_q     <= 1'b0;
      vclk_q     <= 1'b0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      line_q     <= 1'b0;
      frame_q    <= 1'b0;
      stage_q[0] <= STAGE_RST;
    end else begin
      div_q   <= div_d;
      tick_q  <= (div_q == DIV_LAST);
      // Rising edge lands half a pixel after the coordinates change.
      vclk_q  <= (CLK_DIV > 1) && (div_q >= DIV_HALF);
      x_q     <= x_d;
      y_q     <= y_d;
      line_q  <= tick_q && x_wrap;
      frame_q <= tick_q && x_wrap && y_wrap;
      if (tick_q) begin
        stage_q[0] <= raw_d;
      end
    end
  end

  for (genvar g = 1; g <= OUT_DELAY; g++) begin : g_dly
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        stage_q[g] <= STAGE_RST;
      end else if (tick_q) begin
        stage_q[g] <= stage_q[g-1];
      end
    end
  end

  assign pix_tick    = tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign video_on    = (x_q < H_VIS_W) && (y_q < V_VIS_W);
  assign line_start  = line_q;
  assign frame_start = frame_q;
  assign hsync       = stage_q[OUT_DELAY][2];
  assign vsync       = stage_q[OUT_DELAY][1];
  assign vga_blank_n = stage_q[OUT_DELAY][0];
  assign vga_sync_n  = 1'b0;
  assign vga_clk     = vclk_q;

endmodule
